// File: rtl/ramo9_pkg.sv
// ramo9_pkg: shared constants for the ramo9_ctrl RAM controller.
// FSM state encodings, response codes and a byte parity helper.
package ramo9_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Response codes returned on resp_err
  localparam logic [1:0] ERR_OK     = 2'b00;
  localparam logic [1:0] ERR_RANGE  = 2'b01;
  localparam logic [1:0] ERR_PARITY = 2'b10;

  // Even-parity bit for one byte: byte plus this bit has an even number of ones
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/ramo9_parity.sv
// ramo9_parity: combinational per-byte even-parity generator and checker.
// par_gen is the parity of each byte of data; par_err flags any byte whose
// stored parity (par_in) disagrees with the generated one.
module ramo9_parity
  import ramo9_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   data,
  input  logic [DATA_W/8-1:0] par_in,
  output logic [DATA_W/8-1:0] par_gen,
  output logic                par_err
);

  // Generate one parity bit per byte and compare against the stored bits
  always_comb begin
    par_gen = '0;
    for (int b = 0; b < DATA_W/8; b++) begin
      par_gen[b] = byte_parity(data[b*8 +: 8]);
    end
    par_err = |(par_gen ^ par_in);
  end

endmodule

// File: rtl/ramo9_ctrl.sv
// ramo9_ctrl: single-port RAM with valid/ready request/response handshake,
// byte-enable writes, registered read data and optional clear after reset.
// Optional feature macro: RAMO9_PARITY_EN adds a per-byte parity array
// (par_mem) checked on reads.
//
// Handshake: a request transfers on a rising edge where req_valid &&
// req_ready; a response transfers where resp_valid && resp_ready. Response
// outputs hold stable while resp_valid && !resp_ready. One request is in
// flight at a time; with resp_ready held high a new request can transfer
// every cycle.
module ramo9_ctrl
  import ramo9_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 1024,
  parameter int ADDR_W       = 16,
  parameter int CLEAR_ON_RST = 0,
  parameter     INIT_FILE    = ""
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic [1:0]          resp_err,
  output logic                busy,
  output logic [1:0]          dbg_state
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  clr_q, clr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        err_q, err_d;

  logic              accept;
  logic              in_range;
  logic              wr_en;
  logic              rdy;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;

  // Full-width address compare, so no aliasing of out-of-range addresses
  assign in_range = ({{(64-ADDR_W){1'b0}}, req_addr} < 64'(DEPTH));
  assign idx      = req_addr[IDX_W-1:0];
  assign rd_word  = mem[idx];
  assign accept   = req_valid & req_ready;
  assign wr_en    = accept & req_we & in_range;

  // Request readiness by state; held low while reset is asserted
  always_comb begin
    rdy = 1'b0;
    case (state_q)
      ST_IDLE: rdy = 1'b1;
      ST_RESP: rdy = resp_ready;
      default: rdy = 1'b0;
    endcase
    req_ready = rdy & resetn;
  end

`ifdef RAMO9_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] par_gen;
  logic          par_err;

  // Writes generate parity from the write data; reads check the stored word
  ramo9_parity #(.DATA_W(DATA_W)) u_parity (
    .data    (req_we ? req_wdata : rd_word),
    .par_in  (par_mem[idx]),
    .par_gen (par_gen),
    .par_err (par_err)
  );

  // Parity storage: cleared with the data array, updated per enabled byte
  always_ff @(posedge clock) begin
    if (state_q == ST_INIT) begin
      par_mem[clr_q] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (req_be[b]) par_mem[idx][b] <= par_gen[b];
      end
    end
  end
`endif

  // Next-state, clear counter and response register computation
  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_INIT: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          clr_d   = '0;
        end
      end
      ST_IDLE: ;
      ST_RESP: if (resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      state_d = ST_RESP;
      if (!in_range) begin
        rdata_d = '0;
        err_d   = ERR_RANGE;
      end else if (req_we) begin
        rdata_d = '0;
        err_d   = ERR_OK;
      end else begin
        rdata_d = rd_word;
        err_d   = ERR_OK;
`ifdef RAMO9_PARITY_EN
        if (par_err) err_d = ERR_PARITY;
`endif
      end
    end
  end

  // Control and response registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= (CLEAR_ON_RST != 0) ? ST_INIT : ST_IDLE;
      clr_q   <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Data array: one zero word per cycle in INIT, byte-enabled writes otherwise
  always_ff @(posedge clock) begin
    if (state_q == ST_INIT) begin
      mem[clr_q] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (req_be[b]) mem[idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
      end
    end
  end

  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign busy       = (state_q == ST_INIT);
  assign dbg_state  = state_q;

endmodule
